// File: rtl/ram_access_arbiter_pkg.sv
// Shared types for the RAM access arbiter: SPI command codes, FSM state
// encodings and requester identity, plus the round-robin pick helper.
package ram_access_arbiter_pkg;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } spi_cmd_t;

    // Plain vector encoding keeps the state register readable in older
    // tools and netlists.
    typedef logic [1:0] arb_state_t;
    localparam arb_state_t ST_IDLE    = 2'd0;
    localparam arb_state_t ST_ACCESS  = 2'd1;
    localparam arb_state_t ST_RD_WAIT = 2'd2;

    typedef enum logic {
        OWN_SPI  = 1'b0,
        OWN_HOST = 1'b1
    } owner_t;

    // When both requesters are ready the one that did not go last wins.
    function automatic owner_t rr_pick(input logic spi_rdy,
                                       input logic host_rdy,
                                       input owner_t last_owner);
        owner_t pick;
        if (spi_rdy && host_rdy) begin
            pick = (last_owner == OWN_HOST) ? OWN_SPI : OWN_HOST;
        end else if (spi_rdy) begin
            pick = OWN_SPI;
        end else begin
            pick = OWN_HOST;
        end
        return pick;
    endfunction

endpackage

// File: rtl/ram_access_arbiter_spi_cmd_capture.sv
// SPI word capture: rx_valid rising-edge detect, command decode, the SPI
// write/read address registers, the single pending-access slot and the
// sticky overflow flag.
module spi_cmd_capture
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEM_WIDTH+1:0] rx_data_i,
    input  logic                 rx_valid_i,
    input  logic                 slot_clear_i,
    output logic                 word_accepted_o,
    output logic                 slot_full_o,
    output logic                 slot_we_o,
    output logic [ADDR_SIZE-1:0] slot_addr_o,
    output logic [MEM_WIDTH-1:0] slot_wdata_o,
    output logic                 spi_ovf_o
);
    import ram_access_arbiter_pkg::*;

    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 slot_full_q, slot_full_d;
    logic                 slot_we_q, slot_we_d;
    logic [ADDR_SIZE-1:0] slot_addr_q, slot_addr_d;
    logic [MEM_WIDTH-1:0] slot_wdata_q, slot_wdata_d;
    logic                 spi_ovf_q, spi_ovf_d;

    logic                 accept;
    spi_cmd_t             cmd;
    logic [MEM_WIDTH-1:0] payload;

    // Decode an accepted word into address updates or a pending-slot fill.
    always_comb begin
        accept       = rx_valid_i & ~rx_valid_q;
        cmd          = spi_cmd_t'(rx_data_i[MEM_WIDTH+1 -: 2]);
        payload      = rx_data_i[MEM_WIDTH-1:0];
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        slot_full_d  = slot_full_q;
        slot_we_d    = slot_we_q;
        slot_addr_d  = slot_addr_q;
        slot_wdata_d = slot_wdata_q;
        spi_ovf_d    = spi_ovf_q;

        if (slot_clear_i) begin
            slot_full_d = 1'b0;
        end

        if (accept) begin
            case (cmd)
                WR_ADDR: wr_addr_d = ADDR_SIZE'(payload);
                RD_ADDR: rd_addr_d = ADDR_SIZE'(payload);
                WR_DATA, RD_DATA: begin
                    // A slot emptying this very cycle can take the new word.
                    if (slot_full_q && !slot_clear_i) begin
                        spi_ovf_d = 1'b1;
                    end else begin
                        slot_full_d = 1'b1;
                        if (cmd == WR_DATA) begin
                            slot_we_d    = 1'b1;
                            slot_addr_d  = wr_addr_q;
                            slot_wdata_d = payload;
                        end else begin
                            slot_we_d    = 1'b0;
                            slot_addr_d  = rd_addr_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Register capture state with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_valid_q   <= 1'b0;
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            slot_full_q  <= 1'b0;
            slot_we_q    <= 1'b0;
            slot_addr_q  <= '0;
            slot_wdata_q <= '0;
            spi_ovf_q    <= 1'b0;
        end else begin
            rx_valid_q   <= rx_valid_i;
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            slot_full_q  <= slot_full_d;
            slot_we_q    <= slot_we_d;
            slot_addr_q  <= slot_addr_d;
            slot_wdata_q <= slot_wdata_d;
            spi_ovf_q    <= spi_ovf_d;
        end
    end

    assign word_accepted_o = accept;
    assign slot_full_o     = slot_full_q;
    assign slot_we_o       = slot_we_q;
    assign slot_addr_o     = slot_addr_q;
    assign slot_wdata_o    = slot_wdata_q;
    assign spi_ovf_o       = spi_ovf_q;

endmodule

// File: rtl/ram_access_arbiter.sv
// Single-port RAM owner shared round-robin between the SPI slave and a
// local host port; returns read data to whichever side issued the read.
//
// state      | meaning
// -----------+--------------------------------------------------------
// ST_IDLE    | no access in flight; arbitrate ready requesters
// ST_ACCESS  | ram_en high for this one cycle; host_gnt if host owns
// ST_RD_WAIT | RAM read data valid; capture it into the owner's return
module ram_access_arbiter
#(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_WIDTH = 8
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [MEM_WIDTH+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [MEM_WIDTH-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [MEM_WIDTH-1:0] host_wdata,
    output logic                 host_gnt,
    output logic                 host_rvalid,
    output logic [MEM_WIDTH-1:0] host_rdata,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [MEM_WIDTH-1:0] ram_wdata,
    input  logic [MEM_WIDTH-1:0] ram_rdata,
    output logic                 spi_ovf
);
    import ram_access_arbiter_pkg::*;

    arb_state_t           state_q, state_d;
    owner_t               last_owner_q, last_owner_d;
    owner_t               winner;
    logic                 ram_en_q, ram_en_d;
    logic                 ram_we_q, ram_we_d;
    logic [ADDR_SIZE-1:0] ram_addr_q, ram_addr_d;
    logic [MEM_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
    logic                 host_gnt_q, host_gnt_d;
    logic                 host_rvalid_q, host_rvalid_d;
    logic [MEM_WIDTH-1:0] host_rdata_q, host_rdata_d;
    logic [MEM_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;

    logic                 word_accepted;
    logic                 slot_full;
    logic                 slot_we;
    logic [ADDR_SIZE-1:0] slot_addr;
    logic [MEM_WIDTH-1:0] slot_wdata;
    logic                 slot_clear;

    spi_cmd_capture #(
        .ADDR_SIZE (ADDR_SIZE),
        .MEM_WIDTH (MEM_WIDTH)
    ) u_spi_cmd_capture (
        .clk             (clk),
        .rst_n           (rst_n),
        .rx_data_i       (rx_data),
        .rx_valid_i      (rx_valid),
        .slot_clear_i    (slot_clear),
        .word_accepted_o (word_accepted),
        .slot_full_o     (slot_full),
        .slot_we_o       (slot_we),
        .slot_addr_o     (slot_addr),
        .slot_wdata_o    (slot_wdata),
        .spi_ovf_o       (spi_ovf)
    );

    // last_owner doubles as the owner of the access currently in flight.
    assign slot_clear = (state_q == ST_ACCESS) && (last_owner_q == OWN_SPI);

    // Arbitration, access issue and read-data return.
    always_comb begin
        winner        = rr_pick(slot_full, host_req, last_owner_q);
        state_d       = state_q;
        last_owner_d  = last_owner_q;
        ram_en_d      = 1'b0;
        ram_we_d      = 1'b0;
        ram_addr_d    = ram_addr_q;
        ram_wdata_d   = ram_wdata_q;
        host_gnt_d    = 1'b0;
        host_rvalid_d = 1'b0;
        host_rdata_d  = host_rdata_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;

        if (word_accepted) begin
            tx_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (slot_full || host_req) begin
                    state_d      = ST_ACCESS;
                    last_owner_d = winner;
                    ram_en_d     = 1'b1;
                    if (winner == OWN_SPI) begin
                        ram_we_d    = slot_we;
                        ram_addr_d  = slot_addr;
                        ram_wdata_d = slot_wdata;
                    end else begin
                        ram_we_d    = host_we;
                        ram_addr_d  = host_addr;
                        ram_wdata_d = host_wdata;
                        host_gnt_d  = 1'b1;
                    end
                end
            end
            ST_ACCESS: begin
                state_d = ram_we_q ? ST_IDLE : ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                state_d = ST_IDLE;
                if (last_owner_q == OWN_SPI) begin
                    tx_data_d  = ram_rdata;
                    tx_valid_d = 1'b1;
                end else begin
                    host_rdata_d  = ram_rdata;
                    host_rvalid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            last_owner_q  <= OWN_HOST;
            ram_en_q      <= 1'b0;
            ram_we_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_wdata_q   <= '0;
            host_gnt_q    <= 1'b0;
            host_rvalid_q <= 1'b0;
            host_rdata_q  <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_owner_q  <= last_owner_d;
            ram_en_q      <= ram_en_d;
            ram_we_q      <= ram_we_d;
            ram_addr_q    <= ram_addr_d;
            ram_wdata_q   <= ram_wdata_d;
            host_gnt_q    <= host_gnt_d;
            host_rvalid_q <= host_rvalid_d;
            host_rdata_q  <= host_rdata_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
        end
    end

    assign ram_en      = ram_en_q;
    assign ram_we      = ram_we_q;
    assign ram_addr    = ram_addr_q;
    assign ram_wdata   = ram_wdata_q;
    assign host_gnt    = host_gnt_q;
    assign host_rvalid = host_rvalid_q;
    assign host_rdata  = host_rdata_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Directed bench for ram_access_arbiter with a behavioural single-port RAM.
module tb_ram_access_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [9:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       host_req = 1'b0;
    logic       host_we = 1'b0;
    logic [7:0] host_addr = '0;
    logic [7:0] host_wdata = '0;
    logic       host_gnt;
    logic       host_rvalid;
    logic [7:0] host_rdata;
    logic       ram_en;
    logic       ram_we;
    logic [7:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata = '0;
    logic       spi_ovf;

    logic [7:0] mem [256];
    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int rvalid_count = 0;
    int txv_count = 0;
    int base;

    ram_access_arbiter #(.ADDR_SIZE(8), .MEM_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .host_req    (host_req),
        .host_we     (host_we),
        .host_addr   (host_addr),
        .host_wdata  (host_wdata),
        .host_gnt    (host_gnt),
        .host_rvalid (host_rvalid),
        .host_rdata  (host_rdata),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .spi_ovf     (spi_ovf)
    );

    always #5 clk = ~clk;

    // Single-port RAM: write on strobe, read data one cycle later.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    always @(negedge clk) begin
        if (ram_en && ram_we) wr_count++;
        if (host_rvalid)      rvalid_count++;
        if (tx_valid)         txv_count++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        rx_valid = 1'b0;
        host_req = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Word accepted on the first edge; returns one edge later.
    task automatic spi_word(input logic [9:0] w);
        rx_data = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
    endtask

    initial begin
        do_reset();
        chk("rst_ram_en", ram_en, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_ram_addr", ram_addr, 0);
        chk("rst_spi_ovf", spi_ovf, 0);

        // 1: SPI write
        spi_word(10'h005);
        base = wr_count;
        spi_word(10'h1A5);
        chk("t1_ram_en", ram_en, 1);
        chk("t1_ram_we", ram_we, 1);
        chk("t1_ram_addr", ram_addr, 8'h05);
        chk("t1_ram_wdata", ram_wdata, 8'hA5);
        tick();
        chk("t1_ram_en_off", ram_en, 0);
        chk("t1_ram_we_off", ram_we, 0);
        chk("t1_tx_valid", tx_valid, 0);
        chk("t1_writes", wr_count - base, 1);

        // 2: SPI read with return path
        spi_word(10'h205);
        spi_word(10'h300);
        chk("t2_ram_en", ram_en, 1);
        chk("t2_ram_we", ram_we, 0);
        chk("t2_ram_addr", ram_addr, 8'h05);
        tick();
        chk("t2_tx_valid_n2", tx_valid, 0);
        tick();
        chk("t2_tx_valid_n3", tx_valid, 1);
        chk("t2_tx_data", tx_data, 8'hA5);
        tick();
        tick();
        chk("t2_tx_valid_held", tx_valid, 1);
        rx_data = 10'h000;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        chk("t2_tx_valid_clr", tx_valid, 0);
        tick();

        // 3: simultaneous host and SPI writes, last_owner = host after reset
        do_reset();
        spi_word(10'h020);
        rx_data = 10'h177;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 8'h10;
        host_wdata = 8'h3C;
        tick();
        chk("t3_spi_en", ram_en, 1);
        chk("t3_spi_addr", ram_addr, 8'h20);
        chk("t3_spi_wdata", ram_wdata, 8'h77);
        chk("t3_no_gnt", host_gnt, 0);
        tick();
        chk("t3_gap", ram_en, 0);
        tick();
        chk("t3_host_en", ram_en, 1);
        chk("t3_host_addr", ram_addr, 8'h10);
        chk("t3_host_wdata", ram_wdata, 8'h3C);
        chk("t3_host_gnt", host_gnt, 1);
        host_req = 1'b0;
        tick();
        chk("t3_gnt_pulse", host_gnt, 0);
        chk("t3_mem20", mem[8'h20], 8'h77);
        chk("t3_mem10", mem[8'h10], 8'h3C);

        // host read of 0x10
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 8'h10;
        tick();
        chk("hr_gnt", host_gnt, 1);
        chk("hr_we", ram_we, 0);
        host_req = 1'b0;
        tick();
        chk("hr_rvalid_n2", host_rvalid, 0);
        tick();
        chk("hr_rvalid_n3", host_rvalid, 1);
        chk("hr_rdata", host_rdata, 8'h3C);
        tick();
        chk("hr_rvalid_pulse", host_rvalid, 0);

        // 4: rx_valid held high -> single write
        spi_word(10'h030);
        base = wr_count;
        rx_data = 10'h1A5;
        rx_valid = 1'b1;
        repeat (20) tick();
        rx_valid = 1'b0;
        tick();
        tick();
        chk("t4_writes", wr_count - base, 1);
        chk("t4_ovf", spi_ovf, 0);
        chk("t4_mem30", mem[8'h30], 8'hA5);

        // 6a: host holding req, two SPI writes; second dropped
        do_reset();
        spi_word(10'h050);
        base = wr_count;
        host_req = 1'b1;
        host_we = 1'b1;
        host_addr = 8'h40;
        host_wdata = 8'h11;
        rx_data = 10'h1B1;
        rx_valid = 1'b1;
        tick();
        chk("t6_host_first", host_gnt, 1);
        chk("t6_host_addr", ram_addr, 8'h40);
        rx_valid = 1'b0;
        tick();
        chk("t6_gap", ram_en, 0);
        rx_data = 10'h1B2;
        rx_valid = 1'b1;
        tick();
        chk("t6_spi_en", ram_en, 1);
        chk("t6_spi_addr", ram_addr, 8'h50);
        chk("t6_spi_wdata", ram_wdata, 8'hB1);
        chk("t6_spi_no_gnt", host_gnt, 0);
        chk("t6_ovf", spi_ovf, 1);
        host_req = 1'b0;
        rx_valid = 1'b0;
        repeat (4) tick();
        chk("t6_writes", wr_count - base, 2);
        chk("t6_mem50", mem[8'h50], 8'hB1);

        // 6b: word arriving in the slot-clearing cycle is stored
        do_reset();
        chk("t6b_ovf_rst", spi_ovf, 0);
        spi_word(10'h060);
        rx_data = 10'h1D1;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        chk("t6b_first_wdata", ram_wdata, 8'hD1);
        rx_data = 10'h1D2;
        rx_valid = 1'b1;
        tick();
        chk("t6b_no_ovf", spi_ovf, 0);
        rx_valid = 1'b0;
        tick();
        chk("t6b_second_en", ram_en, 1);
        chk("t6b_second_wdata", ram_wdata, 8'hD2);
        chk("t6b_second_addr", ram_addr, 8'h60);
        tick();

        // 5: reset during a host read ACCESS
        do_reset();
        spi_word(10'h205);
        rx_data = 10'h300;
        rx_valid = 1'b1;
        host_req = 1'b1;
        host_we = 1'b0;
        host_addr = 8'h10;
        tick();
        chk("t5_in_access", ram_en, 1);
        rst_n = 1'b0;
        rx_valid = 1'b0;
        host_req = 1'b0;
        tick();
        chk("t5_ram_en", ram_en, 0);
        chk("t5_ram_we", ram_we, 0);
        chk("t5_ram_addr", ram_addr, 0);
        chk("t5_ram_wdata", ram_wdata, 0);
        chk("t5_host_gnt", host_gnt, 0);
        chk("t5_host_rvalid", host_rvalid, 0);
        chk("t5_host_rdata", host_rdata, 0);
        chk("t5_tx_valid", tx_valid, 0);
        chk("t5_tx_data", tx_data, 0);
        chk("t5_ovf", spi_ovf, 0);
        rst_n = 1'b1;
        rvalid_count = 0;
        txv_count = 0;
        repeat (6) tick();
        chk("t5_no_rvalid", rvalid_count, 0);
        chk("t5_no_txvalid", txv_count, 0);
        chk("t5_idle_en", ram_en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
Owns the port of the single-port RAM and shares it between two requesters: the SPI slave (10-bit rx_data words, 8-bit tx_data return) and a local host port. It decodes SPI command words, holds the SPI write and read address registers, and arbitrates RAM accesses round-robin. It returns read data to the SPI slave via tx_data/tx_valid. It sits between SPI_slave and the RAM in the top-level wrapper.

Parameters:
ADDR_SIZE, 8, RAM address width
MEM_WIDTH, 8, RAM data width (SPI word width = MEM_WIDTH+2)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
rx_data  in  MEM_WIDTH+2  SPI word; [9:8] = command, [7:0] = payload
rx_valid  in  1  SPI word valid; level, held high by slave until its IDLE
tx_data  out  MEM_WIDTH  read data to SPI slave
tx_valid  out  1  tx_data valid
host_req  in  1  host access request, held until host_gnt
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_SIZE  host address
host_wdata  in  MEM_WIDTH  host write data
host_gnt  out  1  one-cycle pulse: host access issued this cycle
host_rvalid  out  1  one-cycle pulse: host_rdata valid
host_rdata  out  MEM_WIDTH  host read data
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_SIZE  RAM address
ram_wdata  out  MEM_WIDTH  RAM write data
ram_rdata  in  MEM_WIDTH  RAM read data, valid 1 cycle after a read strobe
spi_ovf  out  1  sticky: SPI word dropped because pending slot was full

Behaviour:
- Reset (rst_n=0 at posedge): every output is 0; wr_addr, rd_addr, pending slot, last_owner (=host), and FSM (=IDLE) are cleared. Reset mid-access aborts the access with no gnt/rvalid/tx_valid.
- SPI capture: an SPI word is accepted only on a rising edge of rx_valid (registered previous value); a held-high level is never re-accepted.
- Command decode on acceptance, with no RAM access for address commands:
  - 00: wr_addr <= payload.
  - 10: rd_addr <= payload.
  - 01: pending slot <= write(wr_addr, payload).
  - 11: pending slot <= read(rd_addr); payload ignored.
  - Any accepted SPI word deasserts tx_valid in the next cycle.
- Overflow: if a 01/11 word is accepted while the pending slot is full, the word is dropped and spi_ovf is set. spi_ovf clears only on reset.
- FSM states are IDLE, ACCESS and RD_WAIT.
- IDLE:
  - If exactly one requester is ready (pending slot full, or host_req), it is the owner.
  - If both are ready, the requester that is not last_owner wins.
  - On the next edge: register ram_en=1, ram_we, ram_addr and ram_wdata from the owner; update last_owner; go to ACCESS.
- ACCESS (ram_en high for exactly this one cycle):
  - If the owner is the host, host_gnt=1 this cycle.
  - If the owner is SPI, the pending slot is cleared at the end of this cycle.
  - Write: next state IDLE. Read: next state RD_WAIT.
- RD_WAIT: capture ram_rdata, then go to IDLE.
  - SPI owner: tx_data <= ram_rdata, and tx_valid is set and held until the next accepted SPI word.
  - Host owner: host_rdata <= ram_rdata, host_rvalid pulses for 1 cycle.
- Latency, counted from the request being visible in IDLE (cycle N):
  - ram_en in N+1.
  - Read data captured at end of N+2.
  - tx_valid / host_rvalid in N+3.
  - Minimum spacing: write 2 cycles, read 3 cycles.
- Simultaneous events:
  - An SPI acceptance in the same cycle the pending slot clears (end of ACCESS) is stored, not an overflow.
  - A 00/10 command during an in-flight SPI access does not affect it; the address was latched at decode.
- ram_we=0 and ram_en=0 whenever the state is not ACCESS; ram_addr and ram_wdata hold their last value.

Decomposition:
- shared_pkg holds:
  - spi_cmd_t enum (WR_ADDR=2'b00, WR_DATA=2'b01, RD_ADDR=2'b10, RD_DATA=2'b11).
  - arb_state_t enum (IDLE, ACCESS, RD_WAIT).
  - owner_t (OWN_SPI, OWN_HOST).
- Sub-module spi_cmd_capture contains the rx_valid edge detector, command decode, wr_addr/rd_addr registers, the pending slot and spi_ovf. The top level contains the FSM, arbitration and the RAM/return-path registers.

Test Plan:
1. SPI 0x005 then 0x1A5 (rising edges, host idle) -> a single ram_en cycle with ram_we=1, addr 0x05, wdata 0xA5; tx_valid stays 0.
2. SPI 0x205 then 0x300, RAM returns 0xA5 -> ram_en read at addr 0x05; tx_data=0xA5 and tx_valid=1 three cycles after the request; tx_valid clears after the next SPI word.
3. host_req write (0x10, 0x3C) and pending SPI write (0x20, 0x77) in the same cycle, last_owner=host -> SPI is granted first, then host (host_gnt in the second ACCESS); both writes land in RAM.
4. rx_valid held high for 20 cycles after 0x1A5 -> exactly one RAM write; spi_ovf stays 0.
5. Host read pending with pending SPI read, then rst_n=0 during ACCESS -> all outputs 0 next cycle; no host_rvalid or tx_valid afterward; spi_ovf=0.
6. Host holds host_req continuously while two SPI writes arrive 1 cycle apart -> the first is granted via round-robin; the second is dropped with spi_ovf=1, unless it arrives in the slot-clearing cycle.
